// File: rtl/raster_line_setup.sv
// Per-line edge/barycentric setup for the raster stage: frame-constant load
// during vertical blanking, one shared-adder step sequence per horizontal blanking.
module raster_line_setup #(
    parameter int X_TRIG = 640,
    parameter int Y_LAST = 479,
    parameter int Y_LOAD = 524
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [9:0]   x,
    input  logic [9:0]   y,
    input  logic         setup_en,
    input  logic [119:0] e_start,
    input  logic [119:0] e_dy,
    input  logic [87:0]  b_start,
    input  logic [87:0]  b_dy,
    output logic [19:0]  e0_init_t1,
    output logic [19:0]  e1_init_t1,
    output logic [19:0]  e2_init_t1,
    output logic [19:0]  e0_init_t2,
    output logic [19:0]  e1_init_t2,
    output logic [19:0]  e2_init_t2,
    output logic [21:0]  bar_iy,
    output logic [21:0]  bar_iz,
    output logic [21:0]  bar2_iy,
    output logic [21:0]  bar2_iz,
    output logic         busy,
    output logic         frame_loaded
);

    localparam logic [9:0] X_TRIG_V = 10'(X_TRIG);
    localparam logic [9:0] Y_LAST_V = 10'(Y_LAST);
    localparam logic [9:0] Y_LOAD_V = 10'(Y_LOAD);

    typedef enum logic [1:0] {IDLE, LOAD, STEP, COMMIT} state_t;
    typedef enum logic {MODE_LOAD, MODE_STEP} mode_t;

    state_t      state, state_next;
    mode_t       mode, mode_next;
    logic [3:0]  idx, idx_next;
    logic [9:0]  x_q;
    logic [21:0] acc  [10];
    logic [21:0] dy_r [10];

    logic        trig;
    logic        is_edge;
    logic [21:0] start_sel, dy_sel, acc_sel, dyr_sel;
    logic [21:0] sum, step_val;

    // Edge-detect on x so a pixel lasting several clocks still triggers once.
    assign trig    = (x == X_TRIG_V) && (x_q != X_TRIG_V);
    assign is_edge = (idx < 4'd6);

    // Element select; edge values are kept sign-extended to 22 bits internally.
    always_comb begin
        start_sel = '0;
        dy_sel    = '0;
        acc_sel   = '0;
        dyr_sel   = '0;
        for (int i = 0; i < 6; i++) begin
            if (idx == 4'(i)) begin
                start_sel = {{2{e_start[20*i+19]}}, e_start[20*i +: 20]};
                dy_sel    = {{2{e_dy[20*i+19]}}, e_dy[20*i +: 20]};
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (idx == 4'(j + 6)) begin
                start_sel = b_start[22*j +: 22];
                dy_sel    = b_dy[22*j +: 22];
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (idx == 4'(k)) begin
                acc_sel = acc[k];
                dyr_sel = dy_r[k];
            end
        end
    end

    assign sum      = acc_sel + dyr_sel;
    assign step_val = is_edge ? {{2{sum[19]}}, sum[19:0]} : sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mode  <= MODE_STEP;
            idx   <= '0;
        end else begin
            state <= state_next;
            mode  <= mode_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        mode_next  = mode;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (trig && (y == Y_LOAD_V) && setup_en) begin
                    state_next = LOAD;
                    mode_next  = MODE_LOAD;
                    idx_next   = '0;
                end else if (trig && (y < Y_LAST_V)) begin
                    state_next = STEP;
                    mode_next  = MODE_STEP;
                    idx_next   = '0;
                end
            end
            LOAD, STEP: begin
                if (idx == 4'd9) begin
                    state_next = COMMIT;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 4'd1;
                end
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign frame_loaded = (state == COMMIT) && (mode == MODE_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            for (int k = 0; k < 10; k++) begin
                acc[k]  <= '0;
                dy_r[k] <= '0;
            end
            e0_init_t1 <= '0;
            e1_init_t1 <= '0;
            e2_init_t1 <= '0;
            e0_init_t2 <= '0;
            e1_init_t2 <= '0;
            e2_init_t2 <= '0;
            bar_iy     <= '0;
            bar_iz     <= '0;
            bar2_iy    <= '0;
            bar2_iz    <= '0;
        end else begin
            x_q <= x;
            if (state == LOAD) begin
                acc[idx]  <= start_sel;
                dy_r[idx] <= dy_sel;
            end else if (state == STEP) begin
                acc[idx] <= step_val;
            end
            // Outputs only move here, well inside horizontal blanking.
            if (state == COMMIT) begin
                e0_init_t1 <= acc[0][19:0];
                e1_init_t1 <= acc[1][19:0];
                e2_init_t1 <= acc[2][19:0];
                e0_init_t2 <= acc[3][19:0];
                e1_init_t2 <= acc[4][19:0];
                e2_init_t2 <= acc[5][19:0];
                bar_iy     <= acc[6];
                bar_iz     <= acc[7];
                bar2_iy    <= acc[8];
                bar2_iz    <= acc[9];
            end
        end
    end

endmodule

// File: tb/tb_raster_line_setup.sv
// Directed bench for raster_line_setup: table of load/step vectors plus
// hand-written timing, skip, clock-rate and mid-sequence reset sequences.
module tb_raster_line_setup;

    logic         clk;
    logic         reset;
    logic [9:0]   x, y;
    logic         setup_en;
    logic [119:0] e_start, e_dy;
    logic [87:0]  b_start, b_dy;
    logic [19:0]  e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2;
    logic [21:0]  bar_iy, bar_iz, bar2_iy, bar2_iz;
    logic         busy, frame_loaded;

    raster_line_setup dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .setup_en(setup_en),
        .e_start(e_start), .e_dy(e_dy), .b_start(b_start), .b_dy(b_dy),
        .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
        .e0_init_t2(e0_init_t2), .e1_init_t2(e1_init_t2), .e2_init_t2(e2_init_t2),
        .bar_iy(bar_iy), .bar_iz(bar_iz), .bar2_iy(bar2_iy), .bar2_iz(bar2_iz),
        .busy(busy), .frame_loaded(frame_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [207:0] all_out = {bar2_iz, bar2_iy, bar_iz, bar_iy,
                            e2_init_t2, e1_init_t2, e0_init_t2,
                            e2_init_t1, e1_init_t1, e0_init_t1};

    typedef struct {
        logic [119:0] es, ed;
        logic [87:0]  bs, bd;
        int           steps;
        int           cpp;
        logic [119:0] exp_e;
        logic [87:0]  exp_b;
    } vec_t;

    vec_t vecs[4];
    int   compared = 0;
    int   mismatched = 0;
    int   early_changes = 0;

    function automatic logic [119:0] pack_e(input int v0, v1, v2, v3, v4, v5);
        return {20'(v5), 20'(v4), 20'(v3), 20'(v2), 20'(v1), 20'(v0)};
    endfunction

    function automatic logic [87:0] pack_b(input int v0, v1, v2, v3);
        return {22'(v3), 22'(v2), 22'(v1), 22'(v0)};
    endfunction

    task automatic set_vec(input int n, input logic [119:0] es, ed, input logic [87:0] bs, bd,
                           input int steps, cpp, input logic [119:0] exp_e, input logic [87:0] exp_b);
        vecs[n].es = es;   vecs[n].ed = ed;
        vecs[n].bs = bs;   vecs[n].bd = bd;
        vecs[n].steps = steps;
        vecs[n].cpp   = cpp;
        vecs[n].exp_e = exp_e;
        vecs[n].exp_b = exp_b;
    endtask

    // Outputs are sampled 1 time unit after the active edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One abbreviated blanking window: x sweeps 636..651, each pixel held cpp clocks.
    task automatic applyStimulus(input logic [9:0] line, input int cpp,
                                 output int busy_cnt, output int fl_cnt);
        logic [207:0] snap;
        snap     = all_out;
        y        = line;
        busy_cnt = 0;
        fl_cnt   = 0;
        for (int p = 0; p < 16; p++) begin
            x = 10'(636 + p);
            for (int c = 0; c < cpp; c++) begin
                tick();
                busy_cnt += int'(busy);
                fl_cnt   += int'(frame_loaded);
                if (x < 10'd640 && all_out !== snap) early_changes++;
            end
        end
    endtask

    task automatic scramble_inputs();
        e_start = 120'({$urandom, $urandom, $urandom, $urandom});
        e_dy    = 120'({$urandom, $urandom, $urandom, $urandom});
        b_start = 88'({$urandom, $urandom, $urandom});
        b_dy    = 88'({$urandom, $urandom, $urandom});
    endtask

    initial begin
        int          bc, fc, total_busy;
        logic [11:0] busy_mask, fl_mask;
        logic [19:0] e0_at10;
        logic [119:0] got_e;
        logic [87:0]  got_b;

        set_vec(0, pack_e(-100, 524287, 7, -1, 0, 1000), pack_e(3, 1, -7, 2, 10, -1000),
                pack_b(262144, 0, -5, 2097151), pack_b(256, 1, 5, 1), 0, 1,
                pack_e(-100, 524287, 7, -1, 0, 1000), pack_b(262144, 0, -5, 2097151));
        set_vec(1, pack_e(-100, 524287, 7, -1, 0, 1000), pack_e(3, 1, -7, 2, 10, -1000),
                pack_b(262144, 0, -5, 2097151), pack_b(256, 1, 5, 1), 1, 1,
                pack_e(-97, -524288, 0, 1, 10, 0), pack_b(262400, 1, 0, -2097152));
        set_vec(2, pack_e(5, -524288, 100, 0, -3, 262144), pack_e(-2, -1, 25, 131072, 1, 65536),
                pack_b(0, 1048576, 12345, -2097152), pack_b(-1, 262144, -10000, 1048576), 4, 1,
                pack_e(-3, 524284, 200, -524288, 1, -524288), pack_b(-4, -2097152, -27655, -2097152));
        set_vec(3, pack_e(5, -524288, 100, 0, -3, 262144), pack_e(-2, -1, 25, 131072, 1, 65536),
                pack_b(0, 1048576, 12345, -2097152), pack_b(-1, 262144, -10000, 1048576), 4, 2,
                pack_e(-3, 524284, 200, -524288, 1, -524288), pack_b(-4, -2097152, -27655, -2097152));

        reset = 1'b1; x = '0; y = '0; setup_en = 1'b0;
        e_start = '0; e_dy = '0; b_start = '0; b_dy = '0;
        tick(); tick();
        reset = 1'b0;
        checkOutput("reset_outputs", 32'(all_out != '0), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frame_loaded", 32'(frame_loaded), 32'd0);

        // Frame load with exact cycle-by-cycle timing.
        setup_en = 1'b1; y = 10'd524;
        e_start = vecs[0].es; e_dy = vecs[0].ed; b_start = vecs[0].bs; b_dy = vecs[0].bd;
        x = 10'd639; tick();
        x = 10'd640;
        busy_mask = '0; fl_mask = '0; e0_at10 = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            busy_mask[k] = busy;
            fl_mask[k]   = frame_loaded;
            if (k == 10) e0_at10 = e0_init_t1;
        end
        x = 10'd700;
        checkOutput("load_busy_window", 32'(busy_mask), 32'h7FF);
        checkOutput("load_frame_loaded_pulse", 32'(fl_mask), 32'h400);
        checkOutput("load_e0_before_commit", 32'(e0_at10), 32'h0);
        checkOutput("load_e0_after_commit", 32'(e0_init_t1), 32'hFFF9C);
        checkOutput("load_bar_iy", 32'(bar_iy), 32'h40000);

        // Table: load a frame, step some lines, compare every element.
        for (int v = 0; v < 4; v++) begin
            setup_en = 1'b1;
            e_start = vecs[v].es; e_dy = vecs[v].ed; b_start = vecs[v].bs; b_dy = vecs[v].bd;
            applyStimulus(10'd524, vecs[v].cpp, bc, fc);
            checkOutput($sformatf("vec%0d_load_busy", v), 32'(bc), 32'd11);
            checkOutput($sformatf("vec%0d_load_pulses", v), 32'(fc), 32'd1);
            scramble_inputs();
            for (int l = 0; l < vecs[v].steps; l++) begin
                applyStimulus(10'(l), vecs[v].cpp, bc, fc);
                checkOutput($sformatf("vec%0d_line%0d_busy", v, l), 32'(bc), 32'd11);
                checkOutput($sformatf("vec%0d_line%0d_pulses", v, l), 32'(fc), 32'd0);
            end
            got_e = all_out[119:0];
            got_b = all_out[207:120];
            for (int i = 0; i < 6; i++)
                checkOutput($sformatf("vec%0d_elem%0d", v, i), 32'(got_e[20*i +: 20]),
                            32'(vecs[v].exp_e[20*i +: 20]));
            for (int j = 0; j < 4; j++)
                checkOutput($sformatf("vec%0d_elem%0d", v, j + 6), 32'(got_b[22*j +: 22]),
                            32'(vecs[v].exp_b[22*j +: 22]));
        end

        // Full frame of stepping: lines 0..478 step, 479 and later blanking lines do not.
        setup_en = 1'b1;
        e_start = vecs[0].es; e_dy = vecs[0].ed; b_start = vecs[0].bs; b_dy = vecs[0].bd;
        applyStimulus(10'd524, 1, bc, fc);
        scramble_inputs();
        total_busy = 0;
        for (int l = 0; l <= 478; l++) begin
            applyStimulus(10'(l), 1, bc, fc);
            total_busy += bc;
        end
        checkOutput("frame_total_busy", 32'(total_busy), 32'd5269);
        checkOutput("frame_e0_line479", 32'(e0_init_t1), 32'd1337);
        checkOutput("frame_bar_iy_line479", 32'(bar_iy), 32'd384768);
        applyStimulus(10'd479, 1, bc, fc);
        checkOutput("line479_busy", 32'(bc), 32'd0);
        checkOutput("line479_e0_held", 32'(e0_init_t1), 32'd1337);
        applyStimulus(10'd480, 1, bc, fc);
        checkOutput("line480_busy", 32'(bc), 32'd0);
        applyStimulus(10'd523, 1, bc, fc);
        checkOutput("line523_busy", 32'(bc), 32'd0);

        // Skipped frame load: nothing happens, next step continues from held state.
        setup_en = 1'b0;
        e_start = pack_e(55, 55, 55, 55, 55, 55); e_dy = '0;
        applyStimulus(10'd524, 1, bc, fc);
        checkOutput("skip_busy", 32'(bc), 32'd0);
        checkOutput("skip_pulses", 32'(fc), 32'd0);
        checkOutput("skip_e0_held", 32'(e0_init_t1), 32'd1337);
        applyStimulus(10'd0, 1, bc, fc);
        checkOutput("skip_then_step_e0", 32'(e0_init_t1), 32'd1340);
        checkOutput("no_change_at_visible_x", 32'(early_changes), 32'd0);

        // Reset in the middle of a step sequence, while idx == 5.
        y = 10'd1;
        x = 10'd639; tick();
        x = 10'd640;
        for (int k = 0; k < 6; k++) tick();
        reset = 1'b1;
        tick();
        checkOutput("midreset_outputs", 32'(all_out != '0), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_frame_loaded", 32'(frame_loaded), 32'd0);
        reset = 1'b0;
        x = 10'd700;
        tick(); tick(); tick();
        checkOutput("postreset_idle_outputs", 32'(all_out != '0), 32'd0);
        applyStimulus(10'd2, 1, bc, fc);
        checkOutput("postreset_step_busy", 32'(bc), 32'd11);
        checkOutput("postreset_step_outputs", 32'(all_out != '0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/raster_line_setup.md
# raster_line_setup

Per-line setup scheduler for the raster stage. It sits between the vertex stage and `raster`, and produces the per-line edge-function init values and barycentric row-start values that `raster` latches at `x == 799`. Vertex-stage frame constants are loaded once per frame during vertical blanking. Each horizontal blanking, a single shared adder steps all ten accumulators, one element per cycle, and the results are committed to stable output registers long before `raster` samples them.

## Interface
Parameters:
- `X_TRIG`, default 640: x value whose first occurrence in a line starts a setup sequence.
- `Y_LAST`, default 479: last visible line; no stepping is done in this line's blanking.
- `Y_LOAD`, default 524: line in which the frame load happens.

Ports (`reset` is reset, synchronous, active-high; `clk` is the clock):
- `clk`  in  1  clock; 1 or 2 clocks per VGA pixel.
- `reset`  in  1  synchronous, active-high.
- `x`  in  10  VGA column counter.
- `y`  in  10  VGA row counter.
- `setup_en`  in  1  sampled when a frame load starts; 0 skips that frame's load.
- `e_start`  in  120  six int20 line-0 edge values; slice i is `[20i+19:20i]`.
- `e_dy`  in  120  six int20 per-line edge steps, same slicing.
- `b_start`  in  88  four Q2.20 line-0 barycentrics; slice j is `[22j+21:22j]`.
- `b_dy`  in  88  four Q2.20 per-line steps.
- `e0_init_t1`, `e1_init_t1`, `e2_init_t1`, `e0_init_t2`, `e1_init_t2`, `e2_init_t2`  out  20 each  committed edge values (element index 0..5).
- `bar_iy`, `bar_iz`, `bar2_iy`, `bar2_iz`  out  22 each  committed barycentrics (element index 6..9).
- `busy`  out  1  high in LOAD, STEP and COMMIT.
- `frame_loaded`  out  1  one-clock pulse on the COMMIT that follows a LOAD.

## Operation
- Internal state:
  - `x_q`: registered copy of `x`.
  - `acc[0..9]`: accumulators; edges are 20-bit, bars are 22-bit.
  - `dy_r[0..9]`: shadow copies of the steps.
  - `idx`: 4-bit element counter.
  - `mode`: LOAD or STEP.
- Trigger: `trig = (x == X_TRIG) && (x_q != X_TRIG)`. It fires exactly once per line, regardless of how many clocks each pixel lasts.
- FSM states: IDLE, LOAD, STEP, COMMIT.
- IDLE:
  - `trig && y == Y_LOAD && setup_en` → LOAD with `idx = 0`.
  - `trig && y < Y_LAST` → STEP with `idx = 0`.
  - Any other trigger is ignored.
- LOAD, cycle with `idx = i`:
  - `acc[i] <= start[i]` and `dy_r[i] <= dy[i]`, with inputs sampled in that cycle.
  - At `i == 9` go to COMMIT; otherwise `idx + 1`.
- STEP, cycle with `idx = i`:
  - `acc[i] <= acc[i] + dy_r[i]` through one shared 22-bit adder. Edge operands are sign-extended and the result is truncated to 20 bits.
  - At `i == 9` go to COMMIT.
- COMMIT:
  - All ten outputs `<= acc` in one cycle.
  - `frame_loaded` pulses if the mode was LOAD.
  - Next state is IDLE.
- Arithmetic is two's-complement with silent wrap at the element width. There is no saturation.
- `setup_en = 0` at the LOAD trigger: no load, outputs hold. Steps in the following frame continue from the held accumulators and the old `dy_r`.
- `e_start`, `e_dy`, `b_start`, `b_dy` are only read in LOAD, so the vertex stage may change them at any other time.
- Triggers that arrive while not in IDLE are ignored. This cannot happen with legal VGA timing.
- Reset, including mid-sequence: the state goes to IDLE and `idx`, `acc`, `dy_r`, `x_q` and all outputs clear to 0. `busy` and `frame_loaded` go to 0.

## Timing
- Let T be the clock in which `trig` is true.
- LOAD or STEP occupies T..T+9, COMMIT is T+10, and new outputs are visible from T+11. `busy` is high T..T+10.
- Worst case at 2 clocks/pixel: outputs are valid by x ≈ 646. Outputs are stable from then through `x == 799`, and always stable for at least 140 pixels before `raster` samples.
- Outputs change only in COMMIT. They never change during visible pixels (x < 640).
- Line sequence:
  - Frame load in line 524 gives line-0 values.
  - The step in line y (0..478) gives line y+1 values.
  - Line 479 and lines 480..523 produce no activity.
- `frame_loaded` is high exactly one clock per loaded frame.

## Test plan
- Reset: assert `reset` during STEP at `idx = 5` → next clock all outputs are 0, `busy = 0`, and the FSM is in IDLE; with reset released and no trigger, outputs stay 0.
- Frame load: `e_start` slice 0 = -100, `b_start` slice 0 = 0x40000, `setup_en = 1`, y = 524, x steps 639→640 → `e0_init_t1 = -100` and `bar_iy = 0x40000` at T+11; `frame_loaded` pulses at T+10; `busy` is high for exactly 11 clocks.
- Line stepping: after the load, `e_dy` slice 0 = 3, run lines 0..478 → after line 478 blanking `e0_init_t1 = -100 + 479*3 = 1337`; no change during line 479 or at x < 640.
- Wrap: `e_start` slice 1 = 524287, `e_dy` slice 1 = 1 → after one step `e1_init_t1 = -524288`; `b_start` slice 3 = 0x1FFFFF, step 1 → `bar2_iz = -0x200000`.
- Skip and clock rate: `setup_en = 0` at the y = 524 trigger → outputs unchanged and no `frame_loaded`; repeat with 2 clocks/pixel (x held for 2 clocks) → exactly one sequence per line, with results identical to the 1 clock/pixel run.
